// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared constants and helpers for the seven-segment scan driver:
//             active-low abcdefg patterns, scan FSM states, anode polarity
//             helpers and a minimum-one clog2.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Active-low abcdefg patterns, a = MSB (0 = segment lit)
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0001100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = SEG_E;

  // Scan controller states: dark (disabled) or scanning
  typedef enum logic [0:0] {
    ST_DARK = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Level that enables one anode line for the given polarity
  function automatic logic an_on(input logic active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

  // Level that disables one anode line for the given polarity
  function automatic logic an_off(input logic active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  // Bits needed to count 0..n-1, never less than one
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_hex_decode
//  Purpose  : Combinational nibble to active-low abcdefg pattern. With
//             hex_mode low, codes 10-15 display the error glyph 'E'.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       hex_mode,
  output logic [6:0] pat
);

  // Map the nibble onto its glyph; non-decimal codes collapse to 'E' in BCD mode
  always_comb begin
    pat = SEG_ERR;
    case (nib)
      4'h0:    pat = SEG_0;
      4'h1:    pat = SEG_1;
      4'h2:    pat = SEG_2;
      4'h3:    pat = SEG_3;
      4'h4:    pat = SEG_4;
      4'h5:    pat = SEG_5;
      4'h6:    pat = SEG_6;
      4'h7:    pat = SEG_7;
      4'h8:    pat = SEG_8;
      4'h9:    pat = SEG_9;
      4'hA:    pat = hex_mode ? SEG_A : SEG_ERR;
      4'hB:    pat = hex_mode ? SEG_B : SEG_ERR;
      4'hC:    pat = hex_mode ? SEG_C : SEG_ERR;
      4'hD:    pat = hex_mode ? SEG_D : SEG_ERR;
      4'hE:    pat = SEG_E;
      4'hF:    pat = hex_mode ? SEG_F : SEG_ERR;
      default: pat = SEG_ERR;
    endcase
  end

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_mux
//  Purpose  : Time-multiplexed N-digit seven-segment driver. Latches a
//             frame of {value, blank, dp} at each frame boundary, scans one
//             digit per refresh slot with a dead-time gap at slot start, and
//             drives registered shared segments plus one-hot anodes.
//  Options  : SEG7_LZB_EN - when defined, digits above the most significant
//             nonzero shadow nibble are blanked (digit 0 never is).
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter  int NUM_DIGITS    = 4,
  parameter  int REFRESH_DIV   = 50000,
  parameter  int DEAD_CYCLES   = 2,
  parameter  int HEX_MODE      = 0,
  parameter  int AN_ACTIVE_LOW = 1,
  localparam int c_scan_w      = clog2_min1(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [c_scan_w-1:0]     scan_idx,
  output logic                    frame_tick
);

  localparam int                  c_cnt_w     = clog2_min1(REFRESH_DIV);
  localparam logic [c_cnt_w-1:0]  c_slot_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_scan_w-1:0] c_idx_last  = c_scan_w'(NUM_DIGITS - 1);
  localparam logic                c_an_on_lvl = an_on(AN_ACTIVE_LOW != 0);
  localparam logic                c_an_off_lvl = an_off(AN_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] c_an_dark = {NUM_DIGITS{c_an_off_lvl}};

  scan_state_t                      r_state;
  scan_state_t                      w_state_nxt;
  logic [c_cnt_w-1:0]               r_slot_cnt;
  logic [c_cnt_w-1:0]               w_slot_cnt_nxt;
  logic [c_scan_w-1:0]              r_scan_idx;
  logic [c_scan_w-1:0]              w_scan_idx_nxt;
  logic                             w_load;
  logic                             w_frame_tick;

  // Frame shadow: the only copy of the inputs the display ever looks at
  logic [NUM_DIGITS-1:0][3:0]       r_sh_value;
  logic [NUM_DIGITS-1:0]            r_sh_blank;
  logic [NUM_DIGITS-1:0]            r_sh_dp;

  logic [6:0]                       r_seg;
  logic [6:0]                       w_seg_nxt;
  logic                             r_seg_dp;
  logic                             w_seg_dp_nxt;
  logic [NUM_DIGITS-1:0]            r_an;
  logic [NUM_DIGITS-1:0]            w_an_nxt;

  logic [3:0]                       w_cur_nib;
  logic                             w_cur_blank;
  logic                             w_cur_dp;
  logic                             w_cur_lzb;
  logic [6:0]                       w_dec_pat;
  logic                             w_in_dead;
  logic [NUM_DIGITS-1:0]            w_lz_blank;

  assign w_cur_nib   = r_sh_value[r_scan_idx];
  assign w_cur_blank = r_sh_blank[r_scan_idx];
  assign w_cur_dp    = r_sh_dp[r_scan_idx];
  assign w_cur_lzb   = w_lz_blank[r_scan_idx];
  assign w_in_dead   = (32'(r_slot_cnt) < 32'(DEAD_CYCLES));

`ifdef SEG7_LZB_EN
  // A digit is a leading zero when it and every digit above it are zero
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lzb
    if (k == 0) begin : g_lsd
      assign w_lz_blank[k] = 1'b0;
    end else begin : g_upper
      assign w_lz_blank[k] = (r_sh_value[NUM_DIGITS-1:k] == '0);
    end
  end
`else
  assign w_lz_blank = '0;
`endif

  seg7_hex_decode u_decode (
    .nib      (w_cur_nib),
    .hex_mode (HEX_MODE != 0),
    .pat      (w_dec_pat)
  );

  // Next state, slot/digit advance, shadow reload strobe and next display pattern
  always_comb begin
    w_state_nxt    = r_state;
    w_slot_cnt_nxt = r_slot_cnt;
    w_scan_idx_nxt = r_scan_idx;
    w_load         = 1'b0;
    w_frame_tick   = 1'b0;
    w_seg_nxt      = SEG_BLANK;
    w_seg_dp_nxt   = 1'b1;
    w_an_nxt       = c_an_dark;
    case (r_state)
      ST_DARK: begin
        w_slot_cnt_nxt = '0;
        w_scan_idx_nxt = '0;
        if (en) begin
          w_state_nxt = ST_SCAN;
          w_load      = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          // Abandon the frame immediately; no partial completion
          w_state_nxt    = ST_DARK;
          w_slot_cnt_nxt = '0;
          w_scan_idx_nxt = '0;
        end else begin
          if (r_slot_cnt == c_slot_last) begin
            w_slot_cnt_nxt = '0;
            if (r_scan_idx == c_idx_last) begin
              w_scan_idx_nxt = '0;
              w_frame_tick   = 1'b1;
              w_load         = 1'b1;
            end else begin
              w_scan_idx_nxt = r_scan_idx + c_scan_w'(1);
            end
          end else begin
            w_slot_cnt_nxt = r_slot_cnt + c_cnt_w'(1);
          end
          if (!w_in_dead) begin
            w_an_nxt             = c_an_dark;
            w_an_nxt[r_scan_idx] = c_an_on_lvl;
            if (!w_cur_blank) begin
              w_seg_dp_nxt = ~w_cur_dp;
              w_seg_nxt    = w_cur_lzb ? SEG_BLANK : w_dec_pat;
            end
          end
        end
      end
      default: begin
        w_state_nxt    = ST_DARK;
        w_slot_cnt_nxt = '0;
        w_scan_idx_nxt = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_DARK;
    else        r_state <= w_state_nxt;
  end

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt <= '0;
      r_scan_idx <= '0;
    end else begin
      r_slot_cnt <= w_slot_cnt_nxt;
      r_scan_idx <= w_scan_idx_nxt;
    end
  end

  // Frame shadow, reloaded only on scan start and at the frame wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_value <= '0;
      r_sh_blank <= '0;
      r_sh_dp    <= '0;
    end else if (w_load) begin
      r_sh_value <= value;
      r_sh_blank <= blank;
      r_sh_dp    <= dp;
    end
  end

  // Registered pad drivers, one clock behind the slot counter and scan index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= SEG_BLANK;
      r_seg_dp <= 1'b1;
      r_an     <= c_an_dark;
    end else begin
      r_seg    <= w_seg_nxt;
      r_seg_dp <= w_seg_dp_nxt;
      r_an     <= w_an_nxt;
    end
  end

  assign seg        = r_seg;
  assign seg_dp     = r_seg_dp;
  assign an         = r_an;
  assign scan_idx   = r_scan_idx;
  assign frame_tick = w_frame_tick;

endmodule : seg7_scan_mux
`default_nettype wire

// File: tb/tb_seg7_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_mux
//  Purpose  : Self-checking bench for seg7_scan_mux (4 digits, 4-clock slots,
//             1 dead cycle, active-low anodes), BCD and hex builds side by
//             side, against a time-indexed reference of the display.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_mux;

  localparam int N = 4;
  localparam int R = 4;
  localparam int D = 1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dp;

  logic [6:0]  seg_b, seg_h;
  logic        segdp_b, segdp_h;
  logic [3:0]  an_b, an_h;
  logic [1:0]  idx_b, idx_h;
  logic        tick_b, tick_h;

  seg7_scan_mux #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .HEX_MODE(0), .AN_ACTIVE_LOW(1)
  ) u_dut_bcd (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .blank(blank), .dp(dp),
    .seg(seg_b), .seg_dp(segdp_b), .an(an_b), .scan_idx(idx_b), .frame_tick(tick_b)
  );

  seg7_scan_mux #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .HEX_MODE(1), .AN_ACTIVE_LOW(1)
  ) u_dut_hex (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .blank(blank), .dp(dp),
    .seg(seg_h), .seg_dp(segdp_h), .an(an_h), .scan_idx(idx_h), .frame_tick(tick_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Glyph table straight from the display definition, index = nibble
  logic [6:0] tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference: m_t counts clocks since slot 0 of the current scan began
  bit          m_run;
  int          m_t;
  logic [15:0] m_val;
  logic [3:0]  m_blank;
  logic [3:0]  m_dp;
  logic [6:0]  m_seg_b, m_seg_h;
  logic        m_sdp;
  logic [3:0]  m_an;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int top_nonzero(input logic [15:0] v);
    int m;
    m = 0;
    for (int k = 0; k < N; k++) begin
      if (4'(v >> (4 * k)) != 4'd0) m = k;
    end
    return m;
  endfunction

  task automatic set_dark();
    m_seg_b = 7'h7F;
    m_seg_h = 7'h7F;
    m_sdp   = 1'b1;
    m_an    = 4'hF;
  endtask

  task automatic latch_frame();
    m_val   = value;
    m_blank = blank;
    m_dp    = dp;
  endtask

  // What the display shows for position t within the scan
  task automatic expected_pattern(input int t);
    int         phase;
    int         k;
    logic [3:0] nib;
    logic       lz;
    phase = t % R;
    k     = (t / R) % N;
    set_dark();
    if (phase >= D) begin
      m_an = 4'hF & ~(4'd1 << k);
      if (!m_blank[2'(k)]) begin
        nib   = 4'(m_val >> (4 * k));
        m_sdp = ~m_dp[2'(k)];
`ifdef SEG7_LZB_EN
        lz = (k > top_nonzero(m_val));
`else
        lz = 1'b0;
`endif
        if (!lz) begin
          m_seg_h = tbl[nib];
          m_seg_b = (nib > 4'd9) ? tbl[14] : tbl[nib];
        end
      end
    end
  endtask

  // Update the reference for one rising edge, using the inputs now applied
  task automatic advance();
    if (!rst_n) begin
      m_run = 1'b0;
      set_dark();
    end else if (!m_run) begin
      set_dark();
      if (en) begin
        m_run = 1'b1;
        m_t   = 0;
        latch_frame();
      end
    end else if (!en) begin
      m_run = 1'b0;
      set_dark();
    end else begin
      expected_pattern(m_t);
      if (m_t % (R * N) == R * N - 1) latch_frame();
      m_t++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] e_idx;
    logic       e_tick;
    e_idx  = m_run ? 2'((m_t / R) % N) : 2'd0;
    e_tick = m_run && en && rst_n && (m_t % (R * N) == R * N - 1);
    chk({tag, "/seg_bcd"}, 16'(seg_b),   16'(m_seg_b));
    chk({tag, "/seg_hex"}, 16'(seg_h),   16'(m_seg_h));
    chk({tag, "/seg_dp"},  16'(segdp_b), 16'(m_sdp));
    chk({tag, "/seg_dp_h"},16'(segdp_h), 16'(m_sdp));
    chk({tag, "/an"},      16'(an_b),    16'(m_an));
    chk({tag, "/an_h"},    16'(an_h),    16'(m_an));
    chk({tag, "/scan_idx"},16'(idx_b),   16'(e_idx));
    chk({tag, "/tick"},    16'(tick_b),  16'(e_tick));
  endtask

  task automatic cycle(input string tag);
    advance();
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    value    = 16'h0;
    blank    = 4'h0;
    dp       = 4'h0;
    m_run    = 1'b0;
    m_t      = 0;
    m_val    = 16'h0;
    m_blank  = 4'h0;
    m_dp     = 4'h0;
    set_dark();

    // Reset state and idle dark
    repeat (3) cycle("reset");
    rst_n = 1'b1;
    repeat (2) cycle("idle_dark");

    // Basic digit scan
    value = 16'h1234;
    en    = 1'b1;
    repeat (2 * R * N + 1) cycle("scan_1234");

    // Non-decimal codes: 'E' in BCD, A/F in hex
    value = 16'h00AF;
    repeat (2 * R * N) cycle("code_00af");

    // Mid-frame input changes must not tear a frame
    value = 16'h5678;
    repeat (5) cycle("midframe_a");
    value = 16'h9ABC;
    repeat (2 * R * N) cycle("midframe_b");

    // Blanking and decimal point, then drop enable inside slot 2
    value = 16'h4321;
    blank = 4'b0100;
    dp    = 4'b0001;
    repeat (2 * R * N) cycle("blank_dp");
    for (int i = 0; i < R * N && !(m_run && ((m_t / R) % N) == 2 && (m_t % R) == 2); i++)
      cycle("seek_slot2");
    en = 1'b0;
    cycle("en_drop");
    repeat (3) cycle("dark_after_drop");

    // Asynchronous reset in the middle of a scan
    blank = 4'h0;
    dp    = 4'h0;
    value = 16'h2468;
    en    = 1'b1;
    repeat (R * N + 6) cycle("pre_reset");
    #2 rst_n = 1'b0;
    #1;
    m_run = 1'b0;
    set_dark();
    check_all("rst_async");
    repeat (3) cycle("rst_hold");
    rst_n = 1'b1;
    repeat (R * N + 2) cycle("post_reset");

    // Randomised traffic with occasional enable toggles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)  value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank = 4'($urandom);
      if ($urandom_range(0, 7) == 0)  dp    = 4'($urandom);
      if ($urandom_range(0, 39) == 0) en    = ~en;
      cycle("random");
    end

    // Leading zeros (blanked only when leading-zero blanking is built in)
    en    = 1'b1;
    blank = 4'h0;
    dp    = 4'b0110;
    value = 16'h0070;
    repeat (2 * R * N + 2) cycle("lz_0070");
    value = 16'h0000;
    repeat (2 * R * N + 2) cycle("lz_zero");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seg7_scan_mux
`default_nettype wire
